branch_predictor: RTL and testbench



---
 rtl/branch_predictor_pkg.sv | 18 +
 rtl/branch_predictor_sat_counter.sv | 24 ++
 rtl/branch_predictor.sv | 155 +++++++++++++++
 tb/tb_branch_predictor.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/branch_predictor_pkg.sv
// Shared CPU constants for the branch predictor: PC width, instruction step
// and the direction-counter encodings used at reset and on allocation.
package branch_predictor_pkg;

   localparam int unsigned CPU_ADDR_W = 32;
   localparam int unsigned PC_STEP    = 4;

   // Weakly not-taken: just below the taken threshold.
   function automatic int unsigned ctr_reset_val(input int unsigned w);
      return (32'd1 << (w - 32'd1)) - 32'd1;
   endfunction

   // Weakly taken: the smallest value with the MSB set.
   function automatic int unsigned ctr_alloc_val(input int unsigned w);
      return 32'd1 << (w - 32'd1);
   endfunction

endpackage

// File: rtl/branch_predictor_sat_counter.sv
// W-bit saturating up/down counter with load-max, evaluated combinationally
// to produce the trained value of one BTB direction counter.
module sat_counter #(
   parameter int unsigned W = 2
) (
   input  logic [W-1:0] cnt_i,
   input  logic         inc_i,
   input  logic         dec_i,
   input  logic         load_max_i,
   output logic [W-1:0] cnt_o
);

   always_comb begin
      cnt_o = cnt_i;
      if (load_max_i) begin
         cnt_o = '1;
      end else if (inc_i && (cnt_i != '1)) begin
         cnt_o = cnt_i + W'(1);
      end else if (dec_i && (cnt_i != '0)) begin
         cnt_o = cnt_i - W'(1);
      end
   end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with per-entry direction counters: combinational IF
// prediction, an IF->ID prediction register, and ID-stage training/mispredict.
module branch_predictor
   import branch_predictor_pkg::*;
#(
   parameter int unsigned ENTRIES = 16,
   parameter int unsigned ADDR_W  = CPU_ADDR_W,
   parameter int unsigned CTR_W   = 2,
   parameter int unsigned CNT_W   = 16
) (
   input  logic              clock,
   input  logic              resetn,
   input  logic [ADDR_W-1:0] if_pc,
   output logic              pred_taken,
   output logic [ADDR_W-1:0] pred_target,
   input  logic              stall,
   input  logic              flush,
   input  logic              upd_valid,
   input  logic [ADDR_W-1:0] upd_pc,
   input  logic              upd_taken,
   input  logic [ADDR_W-1:0] upd_target,
   input  logic [ADDR_W-1:0] upd_fallthru,
   input  logic              upd_is_jump,
   output logic              mispredict,
   output logic [ADDR_W-1:0] correct_pc,
   output logic [CNT_W-1:0]  hit_count,
   output logic [CNT_W-1:0]  miss_count
);

   localparam int unsigned IDX_W = $clog2(ENTRIES);
   localparam int unsigned TAG_W = ADDR_W - IDX_W - 2;
   localparam logic [CTR_W-1:0] CTR_RST   = CTR_W'(ctr_reset_val(CTR_W));
   localparam logic [CTR_W-1:0] CTR_ALLOC = CTR_W'(ctr_alloc_val(CTR_W));

   logic              valid_q  [ENTRIES];
   logic [TAG_W-1:0]  tag_q    [ENTRIES];
   logic [ADDR_W-1:0] target_q [ENTRIES];
   logic [CTR_W-1:0]  ctr_q    [ENTRIES];

   logic              id_pv_q;
   logic              id_taken_q;
   logic [ADDR_W-1:0] id_target_q;
   logic [CNT_W-1:0]  hit_count_q;
   logic [CNT_W-1:0]  miss_count_q;
   logic [CNT_W-1:0]  hit_count_d;
   logic [CNT_W-1:0]  miss_count_d;

   logic [IDX_W-1:0]  if_idx;
   logic [TAG_W-1:0]  if_tag;
   logic              if_hit;
   logic [IDX_W-1:0]  upd_idx;
   logic [TAG_W-1:0]  upd_tag;
   logic              upd_hit;
   logic              upd_en;
   logic              upd_write;
   logic [CTR_W-1:0]  ctr_base;
   logic [CTR_W-1:0]  ctr_d;
   logic              unused_pc_bits;

   // Low PC bits are always zero for word-aligned instructions.
   assign unused_pc_bits = ^{if_pc[1:0], upd_pc[1:0]};

   // ---------------- IF lookup ----------------
   assign if_idx      = if_pc[IDX_W+1:2];
   assign if_tag      = if_pc[ADDR_W-1:IDX_W+2];
   assign if_hit      = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
   assign pred_taken  = if_hit && ctr_q[if_idx][CTR_W-1];
   assign pred_target = pred_taken ? target_q[if_idx] : (if_pc + ADDR_W'(PC_STEP));

   // ---------------- ID resolution ----------------
   assign upd_en     = upd_valid && !stall;
   assign mispredict = upd_en && id_pv_q &&
                       ((id_taken_q != upd_taken) ||
                        (id_taken_q && upd_taken && (id_target_q != upd_target)));
   assign correct_pc = upd_taken ? upd_target : upd_fallthru;

   assign upd_idx = upd_pc[IDX_W+1:2];
   assign upd_tag = upd_pc[ADDR_W-1:IDX_W+2];
   assign upd_hit = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);

   // A miss that resolves not-taken leaves the table untouched.
   assign upd_write = upd_en && (upd_hit || upd_taken);
   assign ctr_base  = upd_hit ? ctr_q[upd_idx] : CTR_ALLOC;

   sat_counter #(
      .W (CTR_W)
   ) u_sat_counter (
      .cnt_i      (ctr_base),
      .inc_i      (upd_hit && upd_taken),
      .dec_i      (upd_hit && !upd_taken),
      .load_max_i (upd_is_jump),
      .cnt_o      (ctr_d)
   );

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         for (int i = 0; i < ENTRIES; i++) begin
            valid_q[i]  <= 1'b0;
            tag_q[i]    <= '0;
            target_q[i] <= '0;
            ctr_q[i]    <= CTR_RST;
         end
      end else if (upd_write) begin
         valid_q[upd_idx] <= 1'b1;
         tag_q[upd_idx]   <= upd_tag;
         ctr_q[upd_idx]   <= ctr_d;
         if (upd_taken) begin
            target_q[upd_idx] <= upd_target;
         end
      end
   end

   // Flush wins over stall: a held prediction can still be invalidated.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         id_pv_q     <= 1'b0;
         id_taken_q  <= 1'b0;
         id_target_q <= '0;
      end else begin
         if (!stall) begin
            id_pv_q     <= 1'b1;
            id_taken_q  <= pred_taken;
            id_target_q <= pred_target;
         end
         if (flush) begin
            id_pv_q <= 1'b0;
         end
      end
   end

   // ---------------- statistics ----------------
   always_comb begin
      hit_count_d  = hit_count_q;
      miss_count_d = miss_count_q;
      if (mispredict) begin
         miss_count_d = miss_count_q + CNT_W'(1);
      end else if (upd_en && id_pv_q) begin
         hit_count_d = hit_count_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         hit_count_q  <= '0;
         miss_count_q <= '0;
      end else begin
         hit_count_q  <= hit_count_d;
         miss_count_q <= miss_count_d;
      end
   end

   assign hit_count  = hit_count_q;
   assign miss_count = miss_count_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor: directed scenarios with literal
// expectations, then randomized traffic against a behavioural BTB model.
module tb_branch_predictor;

   localparam int unsigned N     = 16;
   localparam int unsigned CMAX  = 3;
   localparam int unsigned CHALF = 2;

   logic        clock;
   logic        resetn;
   logic [31:0] if_pc;
   logic        pred_taken;
   logic [31:0] pred_target;
   logic        stall;
   logic        flush;
   logic        upd_valid;
   logic [31:0] upd_pc;
   logic        upd_taken;
   logic [31:0] upd_target;
   logic [31:0] upd_fallthru;
   logic        upd_is_jump;
   logic        mispredict;
   logic [31:0] correct_pc;
   logic [15:0] hit_count;
   logic [15:0] miss_count;

   int unsigned checks = 0;
   int unsigned errors = 0;

   branch_predictor #(
      .ENTRIES (16),
      .ADDR_W  (32),
      .CTR_W   (2),
      .CNT_W   (16)
   ) dut (
      .clock        (clock),
      .resetn       (resetn),
      .if_pc        (if_pc),
      .pred_taken   (pred_taken),
      .pred_target  (pred_target),
      .stall        (stall),
      .flush        (flush),
      .upd_valid    (upd_valid),
      .upd_pc       (upd_pc),
      .upd_taken    (upd_taken),
      .upd_target   (upd_target),
      .upd_fallthru (upd_fallthru),
      .upd_is_jump  (upd_is_jump),
      .mispredict   (mispredict),
      .correct_pc   (correct_pc),
      .hit_count    (hit_count),
      .miss_count   (miss_count)
   );

   // ---------------- clock ----------------
   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   bit          m_valid [N];
   int unsigned m_tag   [N];
   logic [31:0] m_tgt   [N];
   int unsigned m_ctr   [N];
   bit          m_pv;
   bit          m_taken;
   logic [31:0] m_id_tgt;
   int unsigned m_hit;
   int unsigned m_miss;

   task automatic model_reset();
      for (int i = 0; i < N; i++) begin
         m_valid[i] = 0;
         m_tag[i]   = 0;
         m_tgt[i]   = 0;
         m_ctr[i]   = CHALF - 1;
      end
      m_pv = 0; m_taken = 0; m_id_tgt = 0; m_hit = 0; m_miss = 0;
   endtask

   // Compare every cycle at the falling edge, then advance the model to the
   // state the next rising edge will produce (inputs are stable until then).
   always @(negedge clock) begin
      int unsigned li, lt, ui, ut;
      bit          lhit, uhit, e_pt, en, e_mis;
      logic [31:0] e_tgt, e_cpc;
      if (!resetn) model_reset();
      li    = (if_pc / 4) % N;
      lt    = if_pc / (4 * N);
      lhit  = m_valid[li] && (m_tag[li] == lt);
      e_pt  = lhit && (m_ctr[li] >= CHALF);
      e_tgt = e_pt ? m_tgt[li] : if_pc + 32'd4;
      en    = resetn && upd_valid && !stall;
      e_mis = en && m_pv && ((m_taken != upd_taken) ||
                             (m_taken && upd_taken && (m_id_tgt != upd_target)));
      e_cpc = upd_taken ? upd_target : upd_fallthru;
      chk("pred_taken", {31'd0, pred_taken}, {31'd0, e_pt});
      chk("pred_target", pred_target, e_tgt);
      chk("mispredict", {31'd0, mispredict}, {31'd0, e_mis});
      chk("correct_pc", correct_pc, e_cpc);
      chk("hit_count", {16'd0, hit_count}, m_hit & 32'hFFFF);
      chk("miss_count", {16'd0, miss_count}, m_miss & 32'hFFFF);
      if (resetn) begin
         if (e_mis) m_miss++;
         else if (en && m_pv) m_hit++;
         if (en) begin
            ui   = (upd_pc / 4) % N;
            ut   = upd_pc / (4 * N);
            uhit = m_valid[ui] && (m_tag[ui] == ut);
            if (uhit) begin
               if (upd_is_jump) m_ctr[ui] = CMAX;
               else if (upd_taken) m_ctr[ui] = (m_ctr[ui] == CMAX) ? CMAX : m_ctr[ui] + 1;
               else m_ctr[ui] = (m_ctr[ui] == 0) ? 0 : m_ctr[ui] - 1;
               if (upd_taken) m_tgt[ui] = upd_target;
            end else if (upd_taken) begin
               m_valid[ui] = 1;
               m_tag[ui]   = ut;
               m_tgt[ui]   = upd_target;
               m_ctr[ui]   = upd_is_jump ? CMAX : CHALF;
            end
         end
         if (!stall) begin
            m_pv = 1; m_taken = e_pt; m_id_tgt = e_tgt;
         end
         if (flush) m_pv = 0;
      end
   end

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic look();
      @(negedge clock);
      #1;
   endtask

   task automatic upd(input logic v, input logic [31:0] pc, input logic t,
                      input logic [31:0] tgt, input logic [31:0] fall, input logic j);
      upd_valid = v; upd_pc = pc; upd_taken = t;
      upd_target = tgt; upd_fallthru = fall; upd_is_jump = j;
   endtask

   logic [31:0] rnd_pc;
   logic [31:0] last_pc;

   function automatic logic [31:0] pick_pc();
      if ($urandom_range(0, 49) == 0) return 32'hFFFF_FFFC;
      return 32'h1000 + ($urandom_range(0, 3) << 6) + ($urandom_range(0, 3) << 2);
   endfunction

   // ---------------- stimulus ----------------
   initial begin
      resetn = 0; if_pc = 32'h100; stall = 0; flush = 0;
      upd(0, 32'h0, 0, 32'h0, 32'h55, 0);
      tick(); tick();
      look();
      chk("rst_pred_taken", {31'd0, pred_taken}, 32'd0);
      chk("rst_pred_target", pred_target, 32'h104);
      chk("rst_hit", {16'd0, hit_count}, 32'd0);
      chk("rst_miss", {16'd0, miss_count}, 32'd0);
      chk("rst_correct_pc", correct_pc, 32'h55);

      tick(); resetn = 1; upd(1, 32'h100, 1, 32'h200, 32'h104, 0);
      tick(); upd(0, 32'h0, 0, 32'h0, 32'h104, 0);
      look();
      chk("alloc_taken", {31'd0, pred_taken}, 32'd1);
      chk("alloc_target", pred_target, 32'h200);

      tick(); upd(1, 32'h100, 0, 32'h200, 32'h104, 0);
      look();
      chk("nt1_mispredict", {31'd0, mispredict}, 32'd1);
      chk("nt1_correct_pc", correct_pc, 32'h104);
      tick();
      tick(); upd(0, 32'h0, 0, 32'h0, 32'h104, 0);
      look();
      chk("nt2_pred_taken", {31'd0, pred_taken}, 32'd0);
      tick(); upd(1, 32'h100, 0, 32'h200, 32'h104, 0);
      tick(); upd(1, 32'h100, 1, 32'h200, 32'h104, 0);
      tick(); upd(0, 32'h0, 0, 32'h0, 32'h104, 0);
      look();
      chk("sat_floor_taken", {31'd0, pred_taken}, 32'd0);

      tick(); if_pc = 32'h140;
      look();
      chk("alias_taken", {31'd0, pred_taken}, 32'd0);
      chk("alias_target", pred_target, 32'h144);
      tick(); upd(1, 32'h140, 1, 32'h400, 32'h144, 0);
      tick(); upd(0, 32'h0, 0, 32'h0, 32'h144, 0); if_pc = 32'h100;
      look();
      chk("evicted_taken", {31'd0, pred_taken}, 32'd0);
      chk("evicted_target", pred_target, 32'h104);
      tick(); if_pc = 32'h140;
      look();
      chk("new_owner_target", pred_target, 32'h400);

      tick(); if_pc = 32'h204; upd(1, 32'h204, 1, 32'h200, 32'h208, 0);
      tick(); upd(0, 32'h0, 0, 32'h0, 32'h208, 0);
      look();
      chk("b204_taken", {31'd0, pred_taken}, 32'd1);
      tick(); stall = 1; if_pc = 32'h300; upd(1, 32'h204, 1, 32'h300, 32'h208, 0);
      for (int i = 0; i < 3; i++) begin
         look();
         chk("stall_no_mispredict", {31'd0, mispredict}, 32'd0);
         if (i < 2) tick();
      end
      tick(); stall = 0;
      look();
      chk("tgt_mispredict", {31'd0, mispredict}, 32'd1);
      chk("tgt_correct_pc", correct_pc, 32'h300);
      tick(); upd(0, 32'h0, 0, 32'h0, 32'h208, 0); if_pc = 32'h204;

      tick(); flush = 1; stall = 1;
      tick(); flush = 0; stall = 0; upd(1, 32'h204, 0, 32'h300, 32'h208, 0);
      look();
      chk("flush_no_mispredict", {31'd0, mispredict}, 32'd0);

      tick(); upd(1, 32'h140, 1, 32'h500, 32'h144, 0); resetn = 0;
      look();
      chk("midrst_hit", {16'd0, hit_count}, 32'd0);
      chk("midrst_miss", {16'd0, miss_count}, 32'd0);
      chk("midrst_taken", {31'd0, pred_taken}, 32'd0);
      tick(); resetn = 1; upd(0, 32'h0, 0, 32'h0, 32'h144, 0); if_pc = 32'h140;
      look();
      chk("postrst_140", {31'd0, pred_taken}, 32'd0);
      chk("postrst_140_tgt", pred_target, 32'h144);

      // Randomized traffic over a small PC pool so entries alias and hit.
      last_pc = 32'h1000;
      for (int c = 0; c < 3000; c++) begin
         tick();
         rnd_pc = pick_pc();
         resetn = ($urandom_range(0, 199) != 0);
         stall  = ($urandom_range(0, 4) == 0);
         flush  = ($urandom_range(0, 9) == 0);
         upd($urandom_range(0, 1) == 1,
             ($urandom_range(0, 1) == 1) ? last_pc : pick_pc(),
             $urandom_range(0, 2) != 0,
             32'h2000 + ($urandom_range(0, 2) << 4),
             32'h3000 + ($urandom_range(0, 7) << 2),
             $urandom_range(0, 6) == 0);
         if (!stall) last_pc = if_pc;
         if_pc = rnd_pc;
      end
      tick(); resetn = 1;
      look();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
